// File: rtl/counter_defs_pkg.sv
// ============================================================================
// Module      : counter_defs_pkg
// Description : Shared definitions for the counter/divider family: a clog2
//               helper, direction encodings and the MODULUS legality check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_defs_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic int clog2(input longint value);
        int result = 0;
        for (longint v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// Legal when 2 <= M <= 2**W; written with clog2 so wide W cannot overflow.
`define COUNTER_CHECK_MODULUS(W, M) \
    if (((M) < 2) || (counter_defs_pkg::clog2(M) > (W))) begin : g_illegal_modulus \
        $fatal(1, "param_counter_divider: MODULUS outside 2..2**WIDTH"); \
    end

`default_nettype wire

// File: rtl/div_toggle_stage.sv
// ============================================================================
// Module      : div_toggle_stage
// Description : 1-bit registered toggle with async active-high reset; a
//               reusable divide-by-2 stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_toggle_stage (
    input  logic clock,
    input  logic reset,
    input  logic toggle,
    output logic q
);

    logic state_q;
    logic state_d;

    always_comb begin
        state_d = state_q ^ toggle;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= 1'b0;
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;

endmodule

`default_nettype wire

// File: rtl/param_counter_divider.sv
// ============================================================================
// Module      : param_counter_divider
// Description : WIDTH-bit up/down modulo-MODULUS counter with a cascadable
//               terminal-count strobe and a 50%-duty divided output.
//               Optional synchronous load when PARAM_COUNTER_LOAD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_counter_divider
    import counter_defs_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             clear,
`ifdef PARAM_COUNTER_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             div_out
);

    `COUNTER_CHECK_MODULUS(WIDTH, MODULUS)

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] load_sat;
    logic             load_active;
    logic             at_terminal;

`ifdef PARAM_COUNTER_LOAD_EN
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);

    assign load_active = load;
    assign load_sat    = ({1'b0, load_value} >= MOD_EXT) ? MAX_COUNT : load_value;
`else
    assign load_active = 1'b0;
    assign load_sat    = '0;
`endif

    assign at_terminal = (up == DIR_UP) ? (count_q == MAX_COUNT) : (count_q == '0);
    assign tc          = enable & ~clear & ~load_active & at_terminal;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load_active) begin
            count_d = load_sat;
        end else if (enable) begin
            if (up == DIR_DOWN) begin
                count_d = (count_q == '0) ? MAX_COUNT : count_q - 1'b1;
            end else begin
                count_d = (count_q == MAX_COUNT) ? '0 : count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // tc already excludes clear and load, so those edges never toggle.
    div_toggle_stage u_div_stage (
        .clock  (clock),
        .reset  (reset),
        .toggle (tc),
        .q      (div_out)
    );

    assign count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_param_counter_divider.sv
// ============================================================================
// Module      : tb_param_counter_divider
// Description : Directed self-checking bench for param_counter_divider,
//               including a two-stage synchronous cascade.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_counter_divider;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       up;
    logic       clear;
    logic [3:0] count;
    logic       tc;
    logic       div_out;
    logic [3:0] hi_count;
    logic       hi_tc;
    logic       hi_div;
`ifdef PARAM_COUNTER_LOAD_EN
    logic       load;
    logic [3:0] load_value;
`endif

    int checks = 0;
    int errors = 0;

    param_counter_divider #(.WIDTH(4), .MODULUS(10)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .up         (up),
        .clear      (clear),
`ifdef PARAM_COUNTER_LOAD_EN
        .load       (load),
        .load_value (load_value),
`endif
        .count      (count),
        .tc         (tc),
        .div_out    (div_out)
    );

    param_counter_divider #(.WIDTH(4), .MODULUS(10)) u_dut_hi (
        .clock      (clock),
        .reset      (reset),
        .enable     (tc),
        .up         (1'b1),
        .clear      (clear),
`ifdef PARAM_COUNTER_LOAD_EN
        .load       (1'b0),
        .load_value (4'd0),
`endif
        .count      (hi_count),
        .tc         (hi_tc),
        .div_out    (hi_div)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic en, input logic u);
        @(negedge clock);
        reset  = 1'b1;
        enable = en;
        up     = u;
        clear  = 1'b0;
        @(negedge clock);
        reset  = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset  = 1'b1;
        enable = 1'b0;
        up     = 1'b1;
        clear  = 1'b0;
        #1;
        checks++;
        if (count !== 4'd0 || div_out !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("FAIL reset_state count=%0d div=%0b tc=%0b want 0 0 0", count, div_out, tc);
        end
        enable = 1'b1;
        up     = 1'b0;
        #1;
        checks++;
        if (tc !== 1'b1) begin
            errors++;
            $display("FAIL reset_tc_down tc=%0b want 1", tc);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_count_up();
        do_reset(1'b1, 1'b1);
        for (int k = 1; k <= 25; k++) begin
            step();
            checks++;
            if (count !== 4'(k % 10) || tc !== (k % 10 == 9) || div_out !== 1'((k / 10) % 2)) begin
                errors++;
                $display("FAIL count_up k=%0d count=%0d tc=%0b div=%0b want %0d %0b %0b",
                         k, count, tc, div_out, k % 10, (k % 10 == 9), (k / 10) % 2);
            end
        end
    endtask

    task automatic test_count_down();
        do_reset(1'b1, 1'b0);
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) step();
            checks++;
            if (count !== 4'((10 - k % 10) % 10) || tc !== ((10 - k % 10) % 10 == 0) ||
                div_out !== 1'(((k + 9) / 10) % 2)) begin
                errors++;
                $display("FAIL count_down k=%0d count=%0d tc=%0b div=%0b want %0d %0b %0b",
                         k, count, tc, div_out, (10 - k % 10) % 10,
                         ((10 - k % 10) % 10 == 0), ((k + 9) / 10) % 2);
            end
        end
    endtask

    task automatic test_clear_hold();
        do_reset(1'b1, 1'b1);
        repeat (6) step();
        clear = 1'b1;
        #1;
        checks++;
        if (count !== 4'd6 || tc !== 1'b0) begin
            errors++;
            $display("FAIL clear_pre count=%0d tc=%0b want 6 0", count, tc);
        end
        step();
        clear = 1'b0;
        checks++;
        if (count !== 4'd0 || div_out !== 1'b0) begin
            errors++;
            $display("FAIL clear_mid count=%0d div=%0b want 0 0", count, div_out);
        end
        repeat (9) step();
        checks++;
        if (count !== 4'd9 || tc !== 1'b1) begin
            errors++;
            $display("FAIL clear_at9 count=%0d tc=%0b want 9 1", count, tc);
        end
        clear = 1'b1;
        #1;
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL clear_tc_suppress tc=%0b want 0", tc);
        end
        step();
        clear  = 1'b0;
        enable = 1'b0;
        checks++;
        if (count !== 4'd0 || div_out !== 1'b0) begin
            errors++;
            $display("FAIL clear_no_toggle count=%0d div=%0b want 0 0", count, div_out);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (count !== 4'd0 || tc !== 1'b0) begin
                errors++;
                $display("FAIL hold k=%0d count=%0d tc=%0b want 0 0", k, count, tc);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1, 1'b1);
        repeat (17) step();
        checks++;
        if (count !== 4'd7 || div_out !== 1'b1) begin
            errors++;
            $display("FAIL async_pre count=%0d div=%0b want 7 1", count, div_out);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (count !== 4'd0 || div_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset count=%0d div=%0b want 0 0", count, div_out);
        end
        #2;
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (count !== 4'(k)) begin
                errors++;
                $display("FAIL async_resume k=%0d count=%0d want %0d", k, count, k);
            end
        end
    endtask

    task automatic test_cascade();
        do_reset(1'b1, 1'b1);
        for (int k = 1; k <= 100; k++) begin
            step();
            if (k % 5 == 0) begin
                checks++;
                if (hi_count !== 4'((k / 10) % 10) || count !== 4'(k % 10)) begin
                    errors++;
                    $display("FAIL cascade k=%0d hi=%0d lo=%0d want %0d %0d",
                             k, hi_count, count, (k / 10) % 10, k % 10);
                end
            end
            if (k == 99) begin
                checks++;
                if (hi_tc !== 1'b1) begin
                    errors++;
                    $display("FAIL cascade_hi_tc tc=%0b want 1", hi_tc);
                end
            end
        end
        checks++;
        if (hi_div !== 1'b1 || hi_tc !== 1'b0) begin
            errors++;
            $display("FAIL cascade_hi_div div=%0b tc=%0b want 1 0", hi_div, hi_tc);
        end
    endtask

`ifdef PARAM_COUNTER_LOAD_EN
    task automatic test_load();
        do_reset(1'b1, 1'b1);
        repeat (9) step();
        load       = 1'b1;
        load_value = 4'd12;
        #1;
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL load_tc tc=%0b want 0", tc);
        end
        step();
        checks++;
        if (count !== 4'd9 || div_out !== 1'b0) begin
            errors++;
            $display("FAIL load_saturate count=%0d div=%0b want 9 0", count, div_out);
        end
        load_value = 4'd3;
        clear      = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("FAIL load_vs_clear count=%0d want 0", count);
        end
        repeat (9) step();
        load_value = 4'd5;
        step();
        load = 1'b0;
        checks++;
        if (count !== 4'd5 || div_out !== 1'b0) begin
            errors++;
            $display("FAIL load_vs_enable count=%0d div=%0b want 5 0", count, div_out);
        end
    endtask
`endif

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        up     = 1'b1;
        clear  = 1'b0;
`ifdef PARAM_COUNTER_LOAD_EN
        load       = 1'b0;
        load_value = 4'd0;
`endif
        test_reset();
        test_count_up();
        test_count_down();
        test_clear_hold();
        test_async_reset();
        test_cascade();
`ifdef PARAM_COUNTER_LOAD_EN
        test_load();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
